// File: rtl/seg_pkg.sv
// Shared types and 7-segment encodings for the display-sharing arbiter.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Segment order is gfedcba in bits [6:0].
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = SEG_0;
            4'h1:    hex7 = SEG_1;
            4'h2:    hex7 = SEG_2;
            4'h3:    hex7 = SEG_3;
            4'h4:    hex7 = SEG_4;
            4'h5:    hex7 = SEG_5;
            4'h6:    hex7 = SEG_6;
            4'h7:    hex7 = SEG_7;
            4'h8:    hex7 = SEG_8;
            4'h9:    hex7 = SEG_9;
            4'hA:    hex7 = SEG_A;
            4'hB:    hex7 = SEG_B;
            4'hC:    hex7 = SEG_C;
            4'hD:    hex7 = SEG_D;
            4'hE:    hex7 = SEG_E;
            default: hex7 = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester search: first set req bit at or above rr_ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic                    found,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        found = 1'b0;
        owner = '0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) begin
                found = 1'b1;
                owner = idx;
            end
        end
    end

endmodule

// File: rtl/seg_share_arbiter.sv
// Time-slices one 7-segment display among NREQ requesters: round-robin slots with a blank gap between.
module seg_share_arbiter
    import seg_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] digit,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        SEG,
    output logic              busy
);

    localparam int IW      = $clog2(NREQ);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_INIT  = CW'(GAP_CYCLES - 1);

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [7:0]      seg_q, seg_d;
    logic            busy_q, busy_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            pick_found;
    logic [IW-1:0]   pick_owner;
    logic [3:0]      pick_digit;
    logic [3:0]      own_digit;
    logic [IW-1:0]   next_ptr;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .owner  (pick_owner)
    );

    always_comb begin
        pick_digit = '0;
        own_digit  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_owner == IW'(i)) pick_digit = digit[4*i +: 4];
            if (owner_q == IW'(i))    own_digit  = digit[4*i +: 4];
        end
    end

    assign next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        seg_d    = seg_q;
        busy_d   = busy_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                seg_d   = SEG_BLANK;
                busy_d  = 1'b0;
                if (pick_found) begin
                    state_d = SHOW;
                    owner_d = pick_owner;
                    grant_d = onehot(pick_owner);
                    seg_d   = {1'b1, hex7(pick_digit)};
                    busy_d  = 1'b1;
                    cnt_d   = HOLD_INIT;
                end
            end
            SHOW: begin
                seg_d = {1'b1, hex7(own_digit)};
                if (!req[owner_q] || cnt_q == '0) begin
                    state_d  = GAP;
                    grant_d  = '0;
                    seg_d    = SEG_BLANK;
                    cnt_d    = GAP_INIT;
                    rr_ptr_d = next_ptr;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    // Registered done must land on the last SHOW cycle, so it is raised one count early.
                    if (cnt_q == CW'(1)) done_d = onehot(owner_q);
                end
            end
            GAP: begin
                grant_d = '0;
                seg_d   = SEG_BLANK;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                seg_d   = SEG_BLANK;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            seg_q    <= SEG_BLANK;
            busy_q   <= 1'b0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            seg_q    <= seg_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign SEG   = seg_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Scoreboard bench for seg_share_arbiter: directed stimulus pushes expected slots, dones and probes.
module tb_seg_share_arbiter;

    logic        clk_2 = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] digit;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [7:0]  SEG;
    logic        busy;

    always #5 clk_2 = ~clk_2;

    seg_share_arbiter #(.NREQ(4), .HOLD_CYCLES(8), .GAP_CYCLES(1)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .req   (req),
        .digit (digit),
        .grant (grant),
        .done  (done),
        .SEG   (SEG),
        .busy  (busy)
    );

    typedef struct {
        logic [3:0] grant;
        logic [7:0] seg;
        int         gap;
    } slot_t;

    typedef struct {
        int         cyc;
        logic [3:0] grant;
        logic [7:0] seg;
        logic       busy;
        logic [3:0] done;
    } probe_t;

    slot_t      slotq[$];
    logic [3:0] doneq[$];
    probe_t     probeq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_2) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_slot(input logic [3:0] g, input logic [7:0] s, input int gap);
        slot_t e;
        e.grant = g; e.seg = s; e.gap = gap;
        slotq.push_back(e);
    endtask

    task automatic push_probe(input int c, input logic [3:0] g, input logic [7:0] s,
                              input logic b, input logic [3:0] d);
        probe_t p;
        p.cyc = c; p.grant = g; p.seg = s; p.busy = b; p.done = d;
        probeq.push_back(p);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    logic [3:0] grant_prev = 4'b0;
    int         last_start = 0;

    always @(negedge clk_2) begin
        slot_t      e;
        probe_t     p;
        logic [3:0] dexp;
        if (grant != 4'b0 && grant != grant_prev) begin
            if (slotq.size() == 0) begin
                total++; bad++;
                $display("FAIL slot_unexpected @cyc %0d: got grant %b want none", cyc, grant);
            end else begin
                e = slotq.pop_front();
                chk("slot_grant", 32'(grant), 32'(e.grant));
                chk("slot_seg", 32'(SEG), 32'(e.seg));
                if (e.gap >= 0) chk("slot_spacing", 32'(cyc - last_start), 32'(e.gap));
            end
            last_start = cyc;
        end
        grant_prev = grant;
        if (done != 4'b0) begin
            if (doneq.size() == 0) begin
                total++; bad++;
                $display("FAIL done_unexpected @cyc %0d: got %b want none", cyc, done);
            end else begin
                dexp = doneq.pop_front();
                chk("done_pulse", 32'(done), 32'(dexp));
            end
        end
        while (probeq.size() > 0 && probeq[0].cyc == cyc) begin
            p = probeq.pop_front();
            chk("probe_grant", 32'(grant), 32'(p.grant));
            chk("probe_seg", 32'(SEG), 32'(p.seg));
            chk("probe_busy", 32'(busy), 32'(p.busy));
            chk("probe_done", 32'(done), 32'(p.done));
        end
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    end

    initial begin
        reset = 1'b1;
        req   = 4'b0;
        digit = 16'h0;

        wait_to(1);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_seg", 32'(SEG), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        wait_to(2);
        reset = 1'b0;

        // Slot interrupted by reset: no done may appear.
        wait_to(3);
        push_slot(4'b0001, 8'hDB, -1);
        req   = 4'b0001;
        digit = 16'h0002;
        wait_to(6);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_seg", 32'(SEG), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        wait_to(7);
        reset = 1'b0;

        // Single requester: full slot, gap, idle, re-grant.
        push_slot(4'b0001, 8'hDB, -1);
        push_slot(4'b0001, 8'hDB, 10);
        doneq.push_back(4'b0001);
        push_probe(8,  4'b0001, 8'hDB, 1'b1, 4'b0000);
        push_probe(15, 4'b0001, 8'hDB, 1'b1, 4'b0001);
        push_probe(16, 4'b0000, 8'h00, 1'b1, 4'b0000);
        push_probe(17, 4'b0000, 8'h00, 1'b0, 4'b0000);
        wait_to(18);
        req = 4'b0000;

        wait_to(21);
        reset = 1'b1;
        wait_to(22);
        reset = 1'b0;

        // Round-robin over all four requesters.
        wait_to(23);
        push_slot(4'b0001, 8'hBF, -1);
        push_slot(4'b0010, 8'h86, 10);
        push_slot(4'b0100, 8'hDB, 10);
        push_slot(4'b1000, 8'hCF, 10);
        push_slot(4'b0001, 8'hBF, 10);
        doneq.push_back(4'b0001);
        doneq.push_back(4'b0010);
        doneq.push_back(4'b0100);
        doneq.push_back(4'b1000);
        push_probe(32, 4'b0000, 8'h00, 1'b1, 4'b0000);
        push_probe(33, 4'b0000, 8'h00, 1'b0, 4'b0000);
        req   = 4'b1111;
        digit = 16'h3210;
        wait_to(64);
        req = 4'b0000;

        // Live digit, early release, then fairness with a pulsed requester.
        wait_to(67);
        push_slot(4'b0010, 8'hED, -1);
        push_slot(4'b0100, 8'h87, 10);
        push_slot(4'b1000, 8'hF7, 5);
        push_slot(4'b0001, 8'hB9, 10);
        push_slot(4'b0001, 8'hB9, 10);
        push_slot(4'b1000, 8'hF7, 10);
        push_slot(4'b0001, 8'hB9, 3);
        doneq.push_back(4'b0010);
        doneq.push_back(4'b1000);
        doneq.push_back(4'b0001);
        doneq.push_back(4'b0001);
        push_probe(70,  4'b0010, 8'hED, 1'b1, 4'b0000);
        push_probe(71,  4'b0010, 8'hF1, 1'b1, 4'b0000);
        push_probe(81,  4'b0000, 8'h00, 1'b1, 4'b0000);
        push_probe(82,  4'b0000, 8'h00, 1'b0, 4'b0000);
        push_probe(114, 4'b0000, 8'h00, 1'b1, 4'b0000);
        req   = 4'b1111;
        digit = 16'hA75C;
        wait_to(70);
        digit = 16'hA7FC;
        wait_to(80);
        req = 4'b1011;
        wait_to(93);
        req = 4'b0001;
        wait_to(112);
        req = 4'b1001;
        wait_to(113);
        req = 4'b0001;
        wait_to(116);
        req = 4'b0000;

        wait_to(125);
        chk("slots_left", 32'(slotq.size()), 32'd0);
        chk("dones_left", 32'(doneq.size()), 32'd0);
        chk("probes_left", 32'(probeq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
